// File: rtl/cv32e40x_xif_result_buffer_if.sv
// Bundle of signals between the XIF result channel, the WB stage and the
// controller on one side and the result buffer on the other. The buffer
// connects through the slave modport. The agent that drives the result
// channel and the WB controls connects through the master modport.
interface cv32e40x_xif_result_buffer_if #(
  parameter int DEPTH      = 2,
  parameter int X_ID_WIDTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Coprocessor result channel
  logic                  result_valid_i;
  logic                  result_ready_o;
  logic [X_ID_WIDTH-1:0] result_id_i;
  logic [31:0]           result_data_i;
  logic [4:0]            result_rd_i;
  logic                  result_we_i;
  logic                  result_exc_i;
  logic [5:0]            result_exccode_i;

  // WB stage and controller inputs
  logic                  wb_xif_en_i;
  logic [X_ID_WIDTH-1:0] wb_id_i;
  logic                  wb_pop_i;
  logic                  flush_i;

  // Head result presented to WB
  logic                  res_valid_o;
  logic [31:0]           res_data_o;
  logic [4:0]            res_rd_o;
  logic                  res_we_o;
  logic                  res_exc_o;
  logic [5:0]            res_exccode_o;
  logic                  id_mismatch_o;
  logic [CNT_W-1:0]      count_o;

  modport slave (
    input  result_valid_i, result_id_i, result_data_i, result_rd_i,
           result_we_i, result_exc_i, result_exccode_i,
           wb_xif_en_i, wb_id_i, wb_pop_i, flush_i,
    output result_ready_o, res_valid_o, res_data_o, res_rd_o, res_we_o,
           res_exc_o, res_exccode_o, id_mismatch_o, count_o
  );

  modport master (
    output result_valid_i, result_id_i, result_data_i, result_rd_i,
           result_we_i, result_exc_i, result_exccode_i,
           wb_xif_en_i, wb_id_i, wb_pop_i, flush_i,
    input  result_ready_o, res_valid_o, res_data_o, res_rd_o, res_we_o,
           res_exc_o, res_exccode_o, id_mismatch_o, count_o
  );
endinterface

// File: rtl/cv32e40x_xif_result_buffer.sv
// In-order buffer for XIF coprocessor results that feeds the WB stage.
// The buffer accepts results whenever it is not full. The readiness does not
// depend on the WB stage, so there is no combinational path from WB back to
// the coprocessor. The head entry goes to WB only while its id matches the
// XIF instruction that WB holds.
// A flush from the controller empties the buffer. A flush takes priority over
// a push and over a pop in the same cycle.
// With BYPASS set, a result that arrives while the buffer is empty is shown to
// WB in the same cycle. If WB retires that result in the same cycle, the result
// is never written into the buffer.
module cv32e40x_xif_result_buffer #(
  parameter int DEPTH      = 2,
  parameter int X_ID_WIDTH = 4,
  parameter int BYPASS     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  cv32e40x_xif_result_buffer_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           data;
    logic [4:0]            rd;
    logic                  we;
    logic                  exc;
    logic [5:0]            exccode;
  } entry_t;

  // Storage and bookkeeping
  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  // Combinational datapath
  entry_t w_in;
  entry_t w_head;
  logic   w_head_vld;
  logic   w_full;
  logic   w_empty;
  logic   w_bypass;
  logic   w_id_match;
  logic   w_res_valid;
  logic   w_pop;
  logic   w_pop_mem;
  logic   w_bypass_consume;
  logic   w_push;

  assign w_in = '{
    id:      bus.result_id_i,
    data:    bus.result_data_i,
    rd:      bus.result_rd_i,
    we:      bus.result_we_i,
    exc:     bus.result_exc_i,
    exccode: bus.result_exccode_i
  };

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // A result offered in the flush cycle is dropped, so it is never forwarded.
  // While reset is held, every output keeps its idle value.
  assign w_bypass = (BYPASS != 0) && w_empty && bus.result_valid_i &&
                    !bus.flush_i && !rst;

  // Select the head: the stored entry at rd_ptr, else the bypassed input, else all zero
  always_comb begin
    w_head     = '0;
    w_head_vld = 1'b0;
    if (!w_empty) begin
      w_head     = r_mem[r_rd_ptr];
      w_head_vld = 1'b1;
    end else if (w_bypass) begin
      w_head     = w_in;
      w_head_vld = 1'b1;
    end
  end

  assign w_id_match  = (w_head.id == bus.wb_id_i);
  assign w_res_valid = w_head_vld && bus.wb_xif_en_i && w_id_match;

  // A retire request that is not backed by a matching head has no effect.
  assign w_pop            = bus.wb_pop_i && w_res_valid && !rst;
  assign w_pop_mem        = w_pop && !w_empty;
  assign w_bypass_consume = w_pop && w_bypass;
  assign w_push           = bus.result_valid_i && !w_full && !bus.flush_i &&
                            !w_bypass_consume && !rst;

  assign bus.result_ready_o = !w_full;
  assign bus.res_valid_o    = w_res_valid;
  assign bus.res_data_o     = w_head.data;
  assign bus.res_rd_o       = w_head.rd;
  assign bus.res_we_o       = w_res_valid && w_head.we;
  assign bus.res_exc_o      = w_res_valid && w_head.exc;
  assign bus.res_exccode_o  = w_head.exccode;
  assign bus.id_mismatch_o  = w_head_vld && bus.wb_xif_en_i && !w_id_match;
  assign bus.count_o        = r_count;

  // Pointer and occupancy update. A flush clears everything and wins over a push or a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_mem) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop_mem})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage. The contents are only visible through the occupancy, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in;
    end
  end

  // Protocol and occupancy checks
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(w_push && w_full))
    else $error("result buffer: push while full");

  a_count_range: assert property (@(posedge clk) disable iff (rst)
    r_count <= CNT_W'(DEPTH))
    else $error("result buffer: count above depth");

  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(bus.wb_pop_i && w_empty && !w_bypass))
    else $error("result buffer: retire while empty");

endmodule

// File: tb/tb_cv32e40x_xif_result_buffer.sv
// Testbench for the XIF result buffer. Two instances run side by side:
// instance 0 without bypass and instance 1 with bypass.
// A queue model checks every output on every cycle. The queue holds the
// results in the order they were accepted.
module tb_cv32e40x_xif_result_buffer;

  localparam int DEPTH = 2;
  localparam int XW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        exc;
    logic [5:0]  exccode;
    logic        en;
    logic [3:0]  wb_id;
    logic        pop;
    logic        flush;
  } stim_t;

  typedef struct packed {
    logic        ready;
    logic        rv;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        exc;
    logic [5:0]  exccode;
    logic        mism;
    logic [1:0]  count;
  } obs_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        exc;
    logic [5:0]  exccode;
  } ent_t;

  stim_t st [2];
  obs_t  ob [2];
  ent_t  mq [2][$];
  int    n_checks = 0;
  int    n_errors = 0;

  cv32e40x_xif_result_buffer_if #(.DEPTH(DEPTH), .X_ID_WIDTH(XW)) bus [2] ();

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      assign bus[gi].result_valid_i   = st[gi].valid;
      assign bus[gi].result_id_i      = st[gi].id;
      assign bus[gi].result_data_i    = st[gi].data;
      assign bus[gi].result_rd_i      = st[gi].rd;
      assign bus[gi].result_we_i      = st[gi].we;
      assign bus[gi].result_exc_i     = st[gi].exc;
      assign bus[gi].result_exccode_i = st[gi].exccode;
      assign bus[gi].wb_xif_en_i      = st[gi].en;
      assign bus[gi].wb_id_i          = st[gi].wb_id;
      assign bus[gi].wb_pop_i         = st[gi].pop;
      assign bus[gi].flush_i          = st[gi].flush;
      assign ob[gi] = {bus[gi].result_ready_o, bus[gi].res_valid_o, bus[gi].res_data_o,
                       bus[gi].res_rd_o, bus[gi].res_we_o, bus[gi].res_exc_o,
                       bus[gi].res_exccode_o, bus[gi].id_mismatch_o, bus[gi].count_o};

      cv32e40x_xif_result_buffer #(
        .DEPTH(DEPTH), .X_ID_WIDTH(XW), .BYPASS(gi)
      ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus[gi])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk_ent(input int k);
    ent_t e;
    e = '{id: st[k].id, data: st[k].data, rd: st[k].rd, we: st[k].we,
          exc: st[k].exc, exccode: st[k].exccode};
    return e;
  endfunction

  // Expected outputs: the oldest queued result, otherwise (bypass only) the incoming one.
  function automatic obs_t expect_out(input int k);
    obs_t e;
    ent_t h;
    logic hv;
    e  = '0;
    hv = 1'b0;
    h  = '{id: 4'd0, data: 32'd0, rd: 5'd0, we: 1'b0, exc: 1'b0, exccode: 6'd0};
    if (mq[k].size() > 0) begin
      h  = mq[k][0];
      hv = 1'b1;
    end else if (k == 1 && st[k].valid && !st[k].flush && !rst) begin
      h  = mk_ent(k);
      hv = 1'b1;
    end
    e.ready = (mq[k].size() < DEPTH);
    e.rv    = hv && st[k].en && (h.id == st[k].wb_id);
    e.mism  = hv && st[k].en && (h.id != st[k].wb_id);
    if (hv) begin
      e.data    = h.data;
      e.rd      = h.rd;
      e.exccode = h.exccode;
    end
    e.we    = e.rv && h.we;
    e.exc   = e.rv && h.exc;
    e.count = 2'(mq[k].size());
    return e;
  endfunction

  task automatic compare(input int k);
    obs_t e;
    e = expect_out(k);
    chk($sformatf("d%0d.ready", k),   32'(ob[k].ready),   32'(e.ready));
    chk($sformatf("d%0d.valid", k),   32'(ob[k].rv),      32'(e.rv));
    chk($sformatf("d%0d.data", k),    ob[k].data,         e.data);
    chk($sformatf("d%0d.rd", k),      32'(ob[k].rd),      32'(e.rd));
    chk($sformatf("d%0d.we", k),      32'(ob[k].we),      32'(e.we));
    chk($sformatf("d%0d.exc", k),     32'(ob[k].exc),     32'(e.exc));
    chk($sformatf("d%0d.exccode", k), 32'(ob[k].exccode), 32'(e.exccode));
    chk($sformatf("d%0d.mismatch", k), 32'(ob[k].mism),   32'(e.mism));
    chk($sformatf("d%0d.count", k),   32'(ob[k].count),   32'(e.count));
  endtask

  // Apply one clock edge to the model
  task automatic update(input int k);
    obs_t e;
    ent_t h;
    logic consumed;
    e        = expect_out(k);
    consumed = 1'b0;
    if (rst || st[k].flush) begin
      mq[k].delete();
    end else begin
      if (st[k].pop && e.rv) begin
        if (mq[k].size() > 0) begin
          h = mq[k].pop_front();
        end else begin
          h        = mk_ent(k);
          consumed = 1'b1;
        end
        $display("[%0t] d%0d retire id=%0d data=%08h%s", $time, k, h.id, h.data,
                 consumed ? " (bypass)" : "");
      end
      if (st[k].valid && e.ready && !consumed) begin
        mq[k].push_back(mk_ent(k));
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic commit();
    compare(0);
    compare(1);
    update(0);
    update(1);
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int k, input logic [3:0] id, input logic [31:0] data);
    st[k].valid   = 1'b1;
    st[k].id      = id;
    st[k].data    = data;
    st[k].rd      = 5'(id + 4'd1);
    st[k].we      = 1'b1;
    st[k].exc     = 1'b0;
    st[k].exccode = 6'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] nid [2];
    logic [3:0] hid;
    logic       legal;
    stim_t      s;

    st[0] = '0;
    st[1] = '0;

    // Reset state
    settle();
    chk("rst.ready", 32'(ob[0].ready), 32'd1);
    chk("rst.count", 32'(ob[0].count), 32'd0);
    commit();
    rst = 1'b0;

    // 1: push id 3, visible on the next cycle
    $display("[%0t] test 1: single result", $time);
    offer(0, 4'd3, 32'hDEADBEEF);
    settle();
    commit();
    st[0] = '0;
    st[0].en = 1'b1; st[0].wb_id = 4'd3; st[0].pop = 1'b1;
    settle();
    chk("t1.valid", 32'(ob[0].rv), 32'd1);
    chk("t1.data",  ob[0].data,    32'hDEADBEEF);
    chk("t1.we",    32'(ob[0].we), 32'd1);
    chk("t1.count", 32'(ob[0].count), 32'd1);
    commit();

    // 2: fill to full, then retire id 1
    $display("[%0t] test 2: fill and drain", $time);
    st[0] = '0; offer(0, 4'd1, 32'h11); settle(); commit();
    st[0] = '0; offer(0, 4'd2, 32'h22); settle(); commit();
    st[0] = '0; offer(0, 4'd3, 32'h33);
    st[0].en = 1'b1; st[0].wb_id = 4'd1; st[0].pop = 1'b1;
    settle();
    chk("t2.ready_full", 32'(ob[0].ready), 32'd0);
    chk("t2.count_full", 32'(ob[0].count), 32'd2);
    chk("t2.head1", ob[0].data, 32'h11);
    commit();
    st[0] = '0; st[0].en = 1'b1; st[0].wb_id = 4'd2;
    settle();
    chk("t2.ready_after", 32'(ob[0].ready), 32'd1);
    chk("t2.valid_id2",   32'(ob[0].rv),    32'd1);
    chk("t2.head2",       ob[0].data,       32'h22);
    commit();

    // 3: steady push+pop across pointer wraps
    $display("[%0t] test 3: streaming push+pop", $time);
    for (int i = 0; i < 8; i++) begin
      st[0] = '0;
      offer(0, 4'(i + 3), 32'h300 + 32'(i));
      st[0].en = 1'b1; st[0].wb_id = 4'(i + 2); st[0].pop = 1'b1;
      settle();
      chk($sformatf("t3.count%0d", i), 32'(ob[0].count), 32'd1);
      chk($sformatf("t3.data%0d", i), ob[0].data, (i == 0) ? 32'h22 : 32'h300 + 32'(i - 1));
      commit();
    end

    // 4: flush with two entries held and a result offered
    $display("[%0t] test 4: flush", $time);
    st[0] = '0; offer(0, 4'd11, 32'h400); settle(); commit();
    st[0] = '0; offer(0, 4'd12, 32'h500); st[0].flush = 1'b1;
    settle();
    chk("t4.ready_flush", 32'(ob[0].ready), 32'd0);
    commit();
    st[0] = '0; st[0].en = 1'b1; st[0].wb_id = 4'd12;
    settle();
    chk("t4.count", 32'(ob[0].count), 32'd0);
    chk("t4.valid", 32'(ob[0].rv),    32'd0);
    commit();

    // 5: id mismatch, retire request ignored
    $display("[%0t] test 5: id mismatch", $time);
    st[0] = '0; offer(0, 4'd5, 32'h55); settle(); commit();
    st[0] = '0; st[0].en = 1'b1; st[0].wb_id = 4'd6; st[0].pop = 1'b1;
    settle();
    chk("t5.mismatch", 32'(ob[0].mism), 32'd1);
    chk("t5.valid",    32'(ob[0].rv),   32'd0);
    commit();
    st[0] = '0; st[0].flush = 1'b1;
    settle();
    chk("t5.count", 32'(ob[0].count), 32'd1);
    commit();

    // 6: bypass instance, result consumed in the arrival cycle
    $display("[%0t] test 6: bypass consume", $time);
    st[0] = '0;
    st[1] = '0;
    offer(1, 4'd7, 32'h77);
    st[1].exc = 1'b1; st[1].exccode = 6'd2;
    st[1].en = 1'b1; st[1].wb_id = 4'd7; st[1].pop = 1'b1;
    settle();
    chk("t6.valid",   32'(ob[1].rv),      32'd1);
    chk("t6.exc",     32'(ob[1].exc),     32'd1);
    chk("t6.exccode", 32'(ob[1].exccode), 32'd2);
    chk("t6.count",   32'(ob[1].count),   32'd0);
    commit();
    st[1] = '0;
    settle();
    chk("t6.count_after", 32'(ob[1].count), 32'd0);
    commit();

    // Asynchronous reset in the middle of operation
    $display("[%0t] reset mid-operation", $time);
    st[0] = '0; offer(0, 4'd1, 32'hA1); offer(1, 4'd1, 32'hB1); settle(); commit();
    st[1] = '0; st[0] = '0; offer(0, 4'd2, 32'hA2); settle(); commit();
    st[0] = '0; offer(0, 4'd3, 32'hA3);
    st[1] = '0;
    settle();
    rst = 1'b1;
    #1;
    mq[0].delete();
    mq[1].delete();
    chk("rstmid.count0", 32'(ob[0].count), 32'd0);
    chk("rstmid.count1", 32'(ob[1].count), 32'd0);
    compare(0);
    compare(1);
    commit();
    rst = 1'b0;
    st[0] = '0;
    settle();
    chk("rstmid.no_push", 32'(ob[0].count), 32'd0);
    commit();

    // Randomized traffic on both instances
    $display("[%0t] random traffic", $time);
    nid[0] = 4'd0;
    nid[1] = 4'd0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        s         = '0;
        s.valid   = ($urandom % 100) < 60;
        s.id      = nid[k];
        s.data    = $urandom;
        s.rd      = 5'($urandom);
        s.we      = 1'($urandom);
        s.exc     = 1'($urandom);
        s.exccode = 6'($urandom);
        s.flush   = ($urandom % 100) < 3;
        s.en      = ($urandom % 100) < 85;
        hid       = (mq[k].size() > 0) ? mq[k][0].id : s.id;
        s.wb_id   = (($urandom % 100) < 80) ? hid : 4'($urandom);
        legal     = (mq[k].size() > 0) || (k == 1 && s.valid && !s.flush);
        s.pop     = legal && (($urandom % 100) < 50);
        st[k]     = s;
        if (s.valid) nid[k] = nid[k] + 4'd1;
      end
      settle();
      commit();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
